sram_rd_streamer: RTL and testbench

- Read-side sequencer directly downstream of the 2048x32 single-port SRAM macro (sram0_2048x32 interface: CEN/WEN active-low, registered address, Q valid the cycle after the read is issued).
- Walks a programmed address range, issues one read per cycle when credit allows, and presents words on a valid/ready stream to the distance-compute datapath.
- Absorbs the SRAM's 1-cycle read latency and downstream backpressure with a 2-entry output buffer, with no bubbles at full throughput.

---
 rtl/kfn_mem_pkg.sv | 7 +
 rtl/stream_fifo2.sv | 33 +++
 rtl/sram_rd_streamer.sv | 91 +++++++++
 tb/tb_sram_rd_streamer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/kfn_mem_pkg.sv
// kfn_mem_pkg: shared SRAM geometry and read-sequencer state encoding.
package kfn_mem_pkg;
    localparam int SRAM_AW = 11;
    localparam int SRAM_DW = 32;
    localparam int SRAM_DEPTH = 2 ** SRAM_AW;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry valid/ready buffer; the head entry drives data/valid.
// Ports: CLK, RSTN (async active-low); push/push_data write side;
//        pop (handshake) read side; data/valid head view; count occupancy 0..2.
module stream_fifo2 #(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] data,
    output logic          valid,
    output logic [1:0]    count
);
    logic [DW-1:0] tail;
    logic [1:0] left;
    assign valid = count != 2'd0;
    // entries still held after this cycle's pop; decides where a push lands
    assign left = count - 2'(pop & valid);
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            data  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push && left == 2'd0) data <= push_data;
            else if (pop) data <= tail;
            if (push && left == 2'd1) tail <= push_data;
            count <= left + 2'(push);
        end
    end
endmodule

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: walks an SRAM address range and streams the words out.
// Ports: CLK, RSTN (async active-low); start/base_addr/length command;
//        busy/done status; sram_cen/sram_wen/sram_a/sram_q SRAM read port;
//        out_valid/out_ready/out_data/out_last output stream.
module sram_rd_streamer
    import kfn_mem_pkg::*;
#(
    parameter int DW = SRAM_DW,
    parameter int AW = SRAM_AW,
    parameter int LW = 12
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    input  logic [DW-1:0] sram_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);
    state_t state;
    logic [AW-1:0] addr, a_last;
    logic [LW-1:0] len, issued, returned;
    logic in_flight, pop, issue;
    logic [1:0] count;
    assign pop = out_valid & out_ready;
    // a word leaving this cycle frees the slot the new read will land in,
    // so it counts as credit; this keeps full throughput bubble-free
    assign issue = state == RUN && ({1'b0, count} + 3'(in_flight) < 3'd2 + 3'(pop));
    assign sram_cen = !issue;
    assign sram_wen = 1'b1;
    assign sram_a = issue ? addr : a_last;
    assign out_last = out_valid && returned == len - LW'(1);
    stream_fifo2 #(.DW(DW)) u_buf (
        .CLK(CLK),
        .RSTN(RSTN),
        .push(in_flight),
        .push_data(sram_q),
        .pop(pop),
        .data(out_data),
        .valid(out_valid),
        .count(count)
    );
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            a_last    <= '0;
            len       <= '0;
            issued    <= '0;
            returned  <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            done      <= 1'b0;
            if (issue) begin
                addr   <= addr + AW'(1);
                a_last <= addr;
                issued <= issued + LW'(1);
            end
            if (pop) returned <= returned + LW'(1);
            case (state)
                IDLE: if (start) begin
                    addr     <= base_addr;
                    len      <= length;
                    issued   <= '0;
                    returned <= '0;
                    state    <= length == '0 ? DONE : RUN;
                    busy     <= length != '0;
                    done     <= length == '0;
                end
                RUN: if (issue && issued == len - LW'(1)) state <= DRAIN;
                DRAIN: if (pop && out_last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb_sram_rd_streamer: table-driven bursts against an SRAM model plus a
// scoreboard of expected words, with hand-written reset sequences.
module tb_sram_rd_streamer;
    import kfn_mem_pkg::*;
    localparam int DW = SRAM_DW;
    localparam int AW = SRAM_AW;
    localparam int LW = 12;
    localparam int LIM = 20000;
    logic CLK = 1'b0, RSTN = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic busy, done, sram_cen, sram_wen, out_valid, out_last;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_q = '0, out_data;
    logic [DW-1:0] mem [0:SRAM_DEPTH-1];
    typedef struct packed {logic [DW-1:0] data; logic last;} exp_t;
    typedef struct {logic [AW-1:0] base; int len; int mode; bit poke; int exp_reads;} vec_t;
    exp_t exp_q [$];
    exp_t mon_e;
    vec_t vecs [6];
    int rd_hits [0:SRAM_DEPTH-1];
    int tests = 0, fails = 0;
    int reads = 0, hs = 0, done_cnt = 0, rmode = 0, pidx = 0;
    logic [5:0] pat = 6'b101001;
    logic [AW-1:0] exp_addr = '0;
    logic stall = 1'b0;
    logic [DW-1:0] held = '0;

    sram_rd_streamer dut (
        .CLK(CLK), .RSTN(RSTN), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_q(sram_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (!sram_cen) sram_q <= mem[sram_a];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge CLK) begin
        if (!RSTN) stall = 1'b0;
        else begin
            if (done) done_cnt++;
            chk("wen_high", sram_wen, 1);
            if (!sram_cen) begin
                chk("rd_addr", sram_a, exp_addr);
                exp_addr++;
                reads++;
                rd_hits[sram_a]++;
            end
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("data", out_data, mon_e.data);
                    chk("last", out_last, mon_e.last);
                end
                hs++;
            end
            chk("outstanding_le2", reads - hs <= 2, 1);
            stall = out_valid && !out_ready;
            held = out_data;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        pidx++;
        out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? pat[pidx % 6] : 1'($urandom_range(0, 1));
    endtask

    task automatic arm(input logic [AW-1:0] b, input int n, input int mode);
        rmode = mode;
        reads = 0;
        hs = 0;
        exp_addr = b;
        foreach (rd_hits[a]) rd_hits[a] = 0;
        for (int i = 0; i < n; i++) exp_q.push_back('{data: mem[AW'(b + i)], last: i == n - 1});
        base_addr = b;
        length = LW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int t, fv, d0, bad;
        d0 = done_cnt;
        fv = -1;
        t = 0;
        arm(v.base, v.len, v.mode);
        while (!done && t < LIM) begin
            chk("busy_during", busy, 1);
            if (out_valid && fv < 0) fv = t;
            start = v.poke && t == 3;
            if (start) begin
                base_addr = 11'h3AB;
                length = LW'(5);
            end
            tick();
            t++;
        end
        start = 1'b0;
        chk("done_timeout", t < LIM, 1);
        if (v.mode == 0) chk("done_latency", t, v.len == 0 ? 0 : v.len + 2);
        if (v.mode == 0 && v.len > 0) chk("first_word_latency", fv, 2);
        chk("busy_at_done", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
        chk("done_pulses", done_cnt, d0 + 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("read_count", reads, v.exp_reads);
        chk("handshakes", hs, v.len);
        for (int i = 0; i < 3; i++) tick();
        chk("no_ghost_reads", reads, v.exp_reads);
        chk("idle_busy", busy, 0);
        if (v.len == SRAM_DEPTH) begin
            bad = 0;
            foreach (rd_hits[a]) if (rd_hits[a] != 1) bad++;
            chk("every_addr_once", bad, 0);
        end
    endtask

    initial begin
        int t, d0;
        for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = DW'(i);
        vecs[0] = '{11'h010, 4, 0, 1'b0, 4};
        vecs[1] = '{11'h7FE, 4, 0, 1'b0, 4};
        vecs[2] = '{11'h020, 8, 1, 1'b1, 8};
        vecs[3] = '{11'h000, 0, 0, 1'b0, 0};
        vecs[4] = '{11'h400, 2048, 2, 1'b0, 2048};
        vecs[5] = '{11'h7FF, 1, 1, 1'b0, 1};
        #2 RSTN = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cen", sram_cen, 1);
        chk("rst_wen", sram_wen, 1);
        chk("rst_a", sram_a, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        RSTN = 1'b1;
        tick();
        tick();
        foreach (vecs[i]) run_burst(vecs[i]);
        d0 = done_cnt;
        arm(11'h050, 10, 0);
        t = 0;
        while (hs < 3 && t < 100) begin
            tick();
            t++;
        end
        chk("reach_3_words", hs, 3);
        RSTN = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cen", sram_cen, 1);
        chk("midrst_done", done, 0);
        chk("midrst_last", out_last, 0);
        exp_q.delete();
        tick();
        tick();
        chk("midrst_no_done", done_cnt, d0);
        RSTN = 1'b1;
        tick();
        run_burst('{11'h060, 5, 0, 1'b0, 5});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
